// File: rtl/f1_pkg.sv
// Shared definitions for the F1 start-light sequencer.
//   state_e       : sequencer states
//   LFSR_*        : width and tap positions of the hold-time LFSR
//   FULL_PATTERN  : light pattern with all eight lights on
//   lfsr_next     : one step of the x^7+x^6+1 Fibonacci LFSR
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    HOLD   = 2'd2,
    TIMING = 2'd3
  } state_e;

  localparam int LFSR_W     = 7;
  localparam int LFSR_TAP_A = 6;
  localparam int LFSR_TAP_B = 5;

  localparam logic [7:0] FULL_PATTERN = 8'hFF;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/f1_start_ctrl_clk_tick.sv
// Light-tick prescaler.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (counter loads TICK_DIV-1)
//   reload : restart the count at TICK_DIV-1 on this edge
//   tick   : high for the one cycle in which the count is zero
module clk_tick #(
  parameter int TICK_DIV = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q - CNT_W'(1);
    if (reload || (cnt_q == '0)) begin
      cnt_d = RELOAD_VAL;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencer: fills eight lights one per tick, holds them for a
// pseudo-random number of ticks, blanks them, then times the driver reaction.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   trigger     : start request, accepted only while idle
//   react       : driver button
//   data_out    : light pattern, bit0 = first light
//   lights_out  : one-cycle pulse when the lights blank after the hold
//   rt_valid    : one-cycle pulse, rt_value updated
//   rt_value    : reaction time in cycles (all-ones on timeout)
//   false_start : one-cycle pulse on a jump start
//   busy        : high whenever not idle
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int                TICK_DIV  = 24,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 7'h01,
  parameter int                RT_W      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trigger,
  input  logic            react,
  output logic [7:0]      data_out,
  output logic            lights_out,
  output logic            rt_valid,
  output logic [RT_W-1:0] rt_value,
  output logic            false_start,
  output logic            busy
);

  localparam logic [RT_W-1:0] RT_ONE = RT_W'(1);
  localparam logic [RT_W-1:0] RT_MAX = {RT_W{1'b1}};

  state_e            state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] hold_q, hold_d;
  logic [RT_W-1:0]   rt_cnt_q, rt_cnt_d;
  logic [RT_W-1:0]   rt_value_q, rt_value_d;
  logic              lights_out_q, lights_out_d;
  logic              rt_valid_q, rt_valid_d;
  logic              false_start_q, false_start_d;
  logic              tick;
  logic              tick_reload;

  clk_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_clk_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .reload(tick_reload),
    .tick  (tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      data_q        <= '0;
      lfsr_q        <= LFSR_SEED;
      hold_q        <= '0;
      rt_cnt_q      <= '0;
      rt_value_q    <= '0;
      lights_out_q  <= 1'b0;
      rt_valid_q    <= 1'b0;
      false_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      lfsr_q        <= lfsr_d;
      hold_q        <= hold_d;
      rt_cnt_q      <= rt_cnt_d;
      rt_value_q    <= rt_value_d;
      lights_out_q  <= lights_out_d;
      rt_valid_q    <= rt_valid_d;
      false_start_q <= false_start_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    lfsr_d        = lfsr_next(lfsr_q);
    hold_d        = hold_q;
    rt_cnt_d      = rt_cnt_q;
    rt_value_d    = rt_value_q;
    lights_out_d  = 1'b0;
    rt_valid_d    = 1'b0;
    false_start_d = 1'b0;
    tick_reload   = 1'b0;

    unique case (state_q)
      IDLE: begin
        data_d = '0;
        if (trigger) begin
          state_d     = FILL;
          tick_reload = 1'b1;
        end
      end

      FILL: begin
        if (react) begin
          data_d        = '0;
          false_start_d = 1'b1;
          state_d       = IDLE;
        end else if (tick) begin
          data_d = {data_q[6:0], 1'b1};
          if ({data_q[6:0], 1'b1} == FULL_PATTERN) begin
            hold_d  = lfsr_q;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        // A press here always counts as a jump start, even on the final tick.
        if (react) begin
          data_d        = '0;
          false_start_d = 1'b1;
          state_d       = IDLE;
        end else if (tick) begin
          if (hold_q == LFSR_W'(1)) begin
            data_d       = '0;
            lights_out_d = 1'b1;
            rt_cnt_d     = '0;
            state_d      = TIMING;
          end else begin
            hold_d = hold_q - LFSR_W'(1);
          end
        end
      end

      TIMING: begin
        rt_cnt_d = rt_cnt_q + RT_ONE;
        // rt_cnt counts cycles already elapsed, so the reported time is one more.
        if (react) begin
          rt_value_d = rt_cnt_q + RT_ONE;
          rt_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (rt_cnt_q == RT_MAX - RT_ONE) begin
          rt_value_d = RT_MAX;
          rt_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        data_d  = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    data_out    = data_q;
    lights_out  = lights_out_q;
    rt_valid    = rt_valid_q;
    rt_value    = rt_value_q;
    false_start = false_start_q;
    busy        = (state_q != IDLE);
  end

endmodule

// File: doc/f1_start_ctrl.md
Name: f1_start_ctrl

Overview:
- Top-level sequencer for the F1 start-light display.
- On a start request it fills the 8 lights one per tick, then holds all lights for a pseudo-random number of ticks, then blanks them ("lights out").
- After lights out it measures driver reaction time in clock cycles and flags jump starts.
- Owns its own tick prescaler and LFSR. It replaces the free-running light FSM as the thing driving the display.

Parameters:
- TICK_DIV, 24, clock cycles per light tick (min 2).
- LFSR_SEED, 7'h01, LFSR reset value (must be nonzero).
- RT_W, 16, width of reaction-time counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- trigger  in  1  start request, level-sampled, honoured only in IDLE.
- react  in  1  driver button, synchronous to clk, level-sampled.
- data_out  out  8  light pattern, bit0 = first light.
- lights_out  out  1  one-cycle pulse on the edge the lights blank after HOLD.
- rt_valid  out  1  one-cycle pulse: rt_value is valid.
- rt_value  out  RT_W  reaction time in cycles, held until next rt_valid.
- false_start  out  1  one-cycle pulse on a jump start.
- busy  out  1  high in every state except IDLE.

Behaviour:
Reset (rst_n low, asynchronous):
- state=IDLE; data_out=0; all pulses 0; rt_value=0.
- Tick counter=TICK_DIV-1; lfsr=LFSR_SEED.
- Reset mid-sequence aborts immediately with no pulse.

LFSR:
- 7-bit Fibonacci, taps x^7+x^6+1.
- Advances every cycle: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}.
- Never 0; period 127.

Tick generator:
- Down-counter; tick=1 during the cycle the count is 0, then reloads TICK_DIV-1.
- Reloaded to TICK_DIV-1 on the edge trigger is accepted, so the first tick-driven update lands exactly TICK_DIV edges after acceptance.

State machine:
- IDLE:
  - data_out=0.
  - trigger=1 -> FILL.
- FILL:
  - On tick: data_out <= {data_out[6:0],1'b1}.
  - On the tick that makes data_out 8'hFF: capture hold=lfsr, go HOLD.
- HOLD:
  - data_out=8'hFF.
  - On each tick: hold <= hold-1.
  - On the tick with hold==1: data_out <= 0, pulse lights_out, rt_cnt <= 0, go TIMING.
  - HOLD therefore lasts hold*TICK_DIV cycles.
- TIMING:
  - data_out=0; rt_cnt increments every cycle.
  - react=1 -> rt_value <= rt_cnt+1, pulse rt_valid, go IDLE.
  - rt_cnt reaches all-ones -> rt_value <= all-ones, pulse rt_valid, go IDLE (timeout).

Boundary rules:
- react=1 in FILL or HOLD (jump start):
  - data_out <= 0, pulse false_start, go IDLE.
  - No lights_out, no rt_valid.
- react and the final HOLD tick in the same cycle: false start wins.
- react=1 on the cycle after lights_out: rt_value=1.
- trigger outside IDLE: ignored.
- trigger and react both high in IDLE: trigger accepted; react is evaluated from FILL on.
- Next state and data_out are registered; pulses are registered and last exactly one cycle.

Decomposition:
- Package f1_pkg holds:
  - state enum {IDLE, FILL, HOLD, TIMING};
  - LFSR width/tap constants;
  - the 8'hFF full-pattern constant.
- One sub-module, clk_tick: TICK_DIV-parameterised prescaler with clk, rst_n, reload, tick.
- The LFSR stays inline.

Test Plan:
- TICK_DIV=4, pulse trigger -> data_out = 01,03,07,0F,1F,3F,7F,FF on successive 4-cycle boundaries, first change 4 edges after acceptance; busy=1 throughout.
- After FF: bench mirrors the LFSR from reset and samples it at HOLD entry as D -> lights_out pulses exactly D*4 cycles after FF appears, and data_out=0 on that same edge.
- react asserted 37 cycles after lights_out -> rt_valid for one cycle, rt_value=37, return to IDLE, busy=0.
- react asserted while data_out=8'h0F -> false_start pulse, data_out=0 next edge, no lights_out, no rt_valid.
- RT_W=4, never press react -> rt_valid with rt_value=4'hF, 15 cycles after lights_out.
- rst_n low mid-HOLD -> data_out=0 immediately, asynchronously; no pulses. trigger re-pulsed during FILL -> no restart; sequence timing unchanged.
